sha2_round_engine: RTL

- Parametrised SHA-2 compression engine. Executes one compression round per clock using Ch, Maj, Σ0 and Σ1 generalised to WORD_W.
- Supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds).
- Sits between the message-schedule block and the digest register bank. It consumes a stream of pre-summed K_t+W_t words via a valid/ready handshake and emits the 8-word digest with optional feed-forward.

---
 rtl/sha2_pkg.sv | 36 +++
 rtl/sha2_round_func.sv | 69 ++++++
 rtl/sha2_round_engine.sv | 112 +++++++++++
 3 files changed

// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 round engine: FSM encoding,
// per-width big-sigma rotation amounts and a rotate helper.
package sha2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2
    } state_e;

    localparam int unsigned SIG0_32_R0 = 2;
    localparam int unsigned SIG0_32_R1 = 13;
    localparam int unsigned SIG0_32_R2 = 22;
    localparam int unsigned SIG1_32_R0 = 6;
    localparam int unsigned SIG1_32_R1 = 11;
    localparam int unsigned SIG1_32_R2 = 25;

    localparam int unsigned SIG0_64_R0 = 28;
    localparam int unsigned SIG0_64_R1 = 34;
    localparam int unsigned SIG0_64_R2 = 39;
    localparam int unsigned SIG1_64_R0 = 14;
    localparam int unsigned SIG1_64_R1 = 18;
    localparam int unsigned SIG1_64_R2 = 41;

    // x holds a w-bit word zero-extended to 64 bits; bits above w are masked.
    function automatic logic [63:0] rotr(
        input logic [63:0]  x,
        input int unsigned  n,
        input int unsigned  w
    );
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return ((x >> n) | (x << (w - n))) & mask;
    endfunction

endpackage

// File: rtl/sha2_round_func.sv
// One SHA-2 compression round, purely combinational.
// Word 7 of the state bundle is A, word 0 is H.
module sha2_round_func
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [7:0][WORD_W-1:0] st_i,
    input  logic [WORD_W-1:0]      kw_i,
    output logic [7:0][WORD_W-1:0] st_o
);

    typedef logic [WORD_W-1:0] word_t;

    localparam bit W64 = (WORD_W == 64);
    localparam int unsigned S0A = W64 ? SIG0_64_R0 : SIG0_32_R0;
    localparam int unsigned S0B = W64 ? SIG0_64_R1 : SIG0_32_R1;
    localparam int unsigned S0C = W64 ? SIG0_64_R2 : SIG0_32_R2;
    localparam int unsigned S1A = W64 ? SIG1_64_R0 : SIG1_32_R0;
    localparam int unsigned S1B = W64 ? SIG1_64_R1 : SIG1_32_R1;
    localparam int unsigned S1C = W64 ? SIG1_64_R2 : SIG1_32_R2;

    function automatic word_t rot(input word_t x, input int unsigned n);
        logic [63:0] r;
        r = rotr(64'(x), n, WORD_W);
        return r[WORD_W-1:0];
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rot(x, S0A) ^ rot(x, S0B) ^ rot(x, S0C);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rot(x, S1A) ^ rot(x, S1B) ^ rot(x, S1C);
    endfunction

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    always_comb begin
        a  = st_i[7];
        b  = st_i[6];
        c  = st_i[5];
        d  = st_i[4];
        e  = st_i[3];
        f  = st_i[2];
        g  = st_i[1];
        h  = st_i[0];
        t1 = h + bsig1(e) + ch(e, f, g) + kw_i;
        t2 = bsig0(a) + maj(a, b, c);
        st_o[7] = t1 + t2;
        st_o[6] = a;
        st_o[5] = b;
        st_o[4] = c;
        st_o[3] = d + t1;
        st_o[2] = e;
        st_o[1] = f;
        st_o[0] = g;
    end

endmodule

// File: rtl/sha2_round_engine.sv
// SHA-2 compression engine: one round per accepted K+W beat,
// then a one-cycle FINAL that presents the digest with done.
module sha2_round_engine
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned ROUNDS   = 64,
    parameter int unsigned FEED_FWD = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*WORD_W-1:0] init_state,
    input  logic                kw_valid,
    input  logic [WORD_W-1:0]   kw_data,
    output logic                kw_ready,
    output logic                busy,
    output logic                done,
    output logic [8*WORD_W-1:0] digest,
    output logic [6:0]          round_idx
);

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    typedef logic [7:0][WORD_W-1:0] state_t;

    state_e state_q, state_d;
    state_t work_q, work_d;
    state_t saved_q, saved_d;
    state_t digest_q, digest_d;
    logic [6:0] round_q, round_d;

    state_t round_nxt;
    state_t final_w;

    sha2_round_func #(
        .WORD_W (WORD_W)
    ) u_round (
        .st_i (work_q),
        .kw_i (kw_data),
        .st_o (round_nxt)
    );

    // The digest is formed from the last round's output so it is already
    // registered and stable during the FINAL cycle when done is raised.
    always_comb begin
        final_w = round_nxt;
        if (FEED_FWD != 0) begin
            for (int i = 0; i < 8; i++) begin
                final_w[i] = round_nxt[i] + saved_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        saved_d  = saved_q;
        digest_d = digest_q;
        round_d  = round_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = init_state;
                    saved_d = init_state;
                    round_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (kw_valid) begin
                    work_d = round_nxt;
                    if (round_q == LAST_ROUND) begin
                        digest_d = final_w;
                        state_d  = ST_FINAL;
                    end else begin
                        round_d = round_q + 7'd1;
                    end
                end
            end
            ST_FINAL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            saved_q  <= '0;
            digest_q <= '0;
            round_q  <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            saved_q  <= saved_d;
            digest_q <= digest_d;
            round_q  <= round_d;
        end
    end

    assign kw_ready  = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINAL);
    assign digest    = digest_q;
    assign round_idx = round_q;

endmodule
